// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scan encoder and its divider.
// Latency: none (types, constants and a constant function only).
// Backpressure: not applicable.
package keypad_pkg;

    // Key-stability FSM states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } kp_state_e;

    // Value of the flag bit that sits above the encoded key code when no key is down
    localparam logic KEY_NONE = 1'b1;

    // Bits needed for a counter that runs 0..max_count-1 (at least one bit)
    function automatic int cnt_width(input int max_count);
        return (max_count <= 2) ? 1 : $clog2(max_count);
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running clock divider: one-cycle tick every DIV_RATIO clk cycles.
// Latency: tick is combinational from the count register (high while count == DIV_RATIO-1).
// Backpressure: none; runs continuously and only stops while clearn is low.
// Ports: clk (rising edge), clearn (async active-low reset), tick (one-cycle pulse).
module tick_divider
    import keypad_pkg::*;
#(
    parameter int DIV_RATIO = 100
) (
    input  logic clk,
    input  logic clearn,
    output logic tick
);

    localparam int CW = cnt_width(DIV_RATIO);

    if (DIV_RATIO < 2) begin : g_bad_div_ratio
        $error("tick_divider: DIV_RATIO must be >= 2");
    end

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            cnt <= '0;
        end else if (cnt == CW'(DIV_RATIO - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == CW'(DIV_RATIO - 1));

endmodule

// File: rtl/keypad_scan_encoder.sv
// Keypad front end: synchronises N key lines, priority-encodes them, debounces
// per code and emits a registered code with a one-cycle active-low load strobe.
// Latency: key stable from sampling edge 0 gives loadn low after edge 2+DEBOUNCE_CYCLES.
// Backpressure: none; enablen high forces IDLE and suppresses strobes.
// Ports: clk, clearn (async active-low), keypad[N_KEYS] raw lines, enablen (active-low
//   entry enable), BCD_OUT last accepted code, loadn strobe, key_held, pgt_1Hz tick.
module keypad_scan_encoder
    import keypad_pkg::*;
#(
    parameter int N_KEYS          = 10,
    parameter int CODE_W          = 4,
    parameter int DEBOUNCE_CYCLES = 100,
    parameter int DIV_RATIO       = 100,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_PERIOD   = 200
) (
    input  logic              clk,
    input  logic              clearn,
    input  logic [N_KEYS-1:0] keypad,
    input  logic              enablen,
    output logic [CODE_W-1:0] BCD_OUT,
    output logic              loadn,
    output logic              key_held,
    output logic              pgt_1Hz
);

    localparam int DB_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = cnt_width(REP_MAX);

    if (N_KEYS < 1 || (2 ** CODE_W) < N_KEYS) begin : g_bad_code_w
        $error("keypad_scan_encoder: CODE_W too narrow for N_KEYS");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("keypad_scan_encoder: DEBOUNCE_CYCLES must be >= 1");
    end
    if (REPEAT_EN != 0 && (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)) begin : g_bad_repeat
        $error("keypad_scan_encoder: repeat delay and period must be >= 1");
    end

    // Highest set line wins; flag bit set means no key is down.
    function automatic logic [CODE_W:0] prio_enc(input logic [N_KEYS-1:0] v);
        logic [CODE_W:0] r;
        r = {KEY_NONE, {CODE_W{1'b0}}};
        for (int i = 0; i < N_KEYS; i++) begin
            if (v[i]) begin
                r = {1'b0, CODE_W'(i)};
            end
        end
        return r;
    endfunction

    logic [N_KEYS-1:0] sync1, sync2;
    logic              code_none;
    logic [CODE_W-1:0] code;

    kp_state_e         state, state_nxt;
    logic [CODE_W-1:0] cand, cand_nxt, bcd_nxt;
    logic [DB_W-1:0]   cnt, cnt_nxt;
    logic [REP_W-1:0]  rep_cnt, rep_cnt_nxt, rep_last;
    logic              rep_first, rep_first_nxt;
    logic              held_nxt;
    logic              strobe;
    logic              div_tick;

    assign {code_none, code} = prio_enc(sync2);

    // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD
    assign rep_last = rep_first ? REP_W'(REPEAT_DELAY - 1) : REP_W'(REPEAT_PERIOD - 1);

    tick_divider #(
        .DIV_RATIO(DIV_RATIO)
    ) u_div (
        .clk   (clk),
        .clearn(clearn),
        .tick  (div_tick)
    );

    always_comb begin
        state_nxt     = state;
        cand_nxt      = cand;
        cnt_nxt       = cnt;
        rep_cnt_nxt   = '0;
        rep_first_nxt = rep_first;
        bcd_nxt       = BCD_OUT;
        held_nxt      = key_held;
        strobe        = 1'b0;

        if (enablen) begin
            // Timer running: keypad ignored, last code kept on BCD_OUT
            state_nxt = IDLE;
            cnt_nxt   = '0;
            held_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    held_nxt = 1'b0;
                    if (!code_none) begin
                        cand_nxt  = code;
                        cnt_nxt   = '0;
                        state_nxt = PRESS_DB;
                    end
                end
                PRESS_DB: begin
                    if (code_none) begin
                        cnt_nxt   = '0;
                        held_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end else if (code != cand) begin
                        cand_nxt = code;
                        cnt_nxt  = '0;
                    end else if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        bcd_nxt       = cand;
                        strobe        = 1'b1;
                        held_nxt      = 1'b1;
                        cnt_nxt       = '0;
                        rep_first_nxt = 1'b1;
                        state_nxt     = HELD;
                    end else begin
                        cnt_nxt = cnt + DB_W'(1);
                    end
                end
                HELD: begin
                    if (code_none) begin
                        cnt_nxt   = '0;
                        state_nxt = REL_DB;
                    end else if (code != BCD_OUT) begin
                        // Rollover: key_held stays up while the new key debounces
                        cand_nxt  = code;
                        cnt_nxt   = '0;
                        state_nxt = PRESS_DB;
                    end else if (REPEAT_EN != 0) begin
                        if (rep_cnt == rep_last) begin
                            strobe        = 1'b1;
                            rep_first_nxt = 1'b0;
                        end else begin
                            rep_cnt_nxt = rep_cnt + REP_W'(1);
                        end
                    end
                end
                REL_DB: begin
                    if (code_none) begin
                        if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                            cnt_nxt   = '0;
                            held_nxt  = 1'b0;
                            state_nxt = IDLE;
                        end else begin
                            cnt_nxt = cnt + DB_W'(1);
                        end
                    end else if (code == BCD_OUT) begin
                        // Same key bounced back: resume without a new strobe
                        cnt_nxt       = '0;
                        rep_first_nxt = 1'b1;
                        state_nxt     = HELD;
                    end else begin
                        cand_nxt  = code;
                        cnt_nxt   = '0;
                        state_nxt = PRESS_DB;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            sync1     <= '0;
            sync2     <= '0;
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            rep_cnt   <= '0;
            rep_first <= 1'b1;
            BCD_OUT   <= '0;
            loadn     <= 1'b1;
            key_held  <= 1'b0;
            pgt_1Hz   <= 1'b0;
        end else begin
            sync1     <= keypad;
            sync2     <= sync1;
            state     <= state_nxt;
            cand      <= cand_nxt;
            cnt       <= cnt_nxt;
            rep_cnt   <= rep_cnt_nxt;
            rep_first <= rep_first_nxt;
            BCD_OUT   <= bcd_nxt;
            loadn     <= ~strobe;
            key_held  <= held_nxt;
            // Key strobe while entering digits, divider tick while the timer runs
            pgt_1Hz   <= enablen ? div_tick : ~loadn;
        end
    end

endmodule
